// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - parametrised up/down modulo counter with prescaler, tc pulse and sticky wrap flag
// Define COUNTER_SATURATE_EN to make the range ends saturate instead of wrap.
module counter_updown_mod #(
  parameter int               WIDTH       = 8,
  parameter int               PRESCALE    = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             ovf
);

  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [PSC_W-1:0] psc;
  logic             step;
  logic             wrap;
  logic [WIDTH-1:0] next_value;

  // A value loaded above limit wraps (or clamps) on the next up step.
  always_comb begin
    step       = en & (psc == PSC_LAST);
    wrap       = 1'b0;
    next_value = value;
    if (up) begin
      if (value >= limit) begin
        wrap = 1'b1;
`ifdef COUNTER_SATURATE_EN
        next_value = limit;
`else
        next_value = '0;
`endif
      end else begin
        next_value = value + ONE;
      end
    end else begin
      if (value == '0) begin
        wrap = 1'b1;
`ifdef COUNTER_SATURATE_EN
        next_value = '0;
`else
        next_value = limit;
`endif
      end else begin
        next_value = value - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= RESET_VALUE;
      psc   <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      value <= load_value;
      psc   <= '0;
      tc    <= 1'b0;
      if (clr_ovf) ovf <= 1'b0;
    end else begin
      tc <= step & wrap;
      if (en) psc <= step ? '0 : psc + PSC_W'(1);
      if (step) value <= next_value;
      // A wrap in the same cycle as clr_ovf keeps the flag set.
      if (step & wrap) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb/tb_counter_updown_mod.sv - directed self-checking bench for counter_updown_mod
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic [7:0] limit = 8'hFF;
  logic       clr_ovf = 1'b0;
  logic [7:0] value;
  logic       tc;
  logic       ovf;
  logic [7:0] value4;
  logic       tc4;
  logic       ovf4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(8), .PRESCALE(1), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value), .limit(limit), .clr_ovf(clr_ovf),
    .value(value), .tc(tc), .ovf(ovf)
  );

  counter_updown_mod #(.WIDTH(8), .PRESCALE(4), .RESET_VALUE(8'h00)) dut4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value), .limit(limit), .clr_ovf(clr_ovf),
    .value(value4), .tc(tc4), .ovf(ovf4)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; up = 1'b1; limit = 8'hFF; load = 1'b0; clr_ovf = 1'b0;
    #17 reset = 1'b1;
    #11 reset = 1'b0;
    checks++;
    if (value !== 8'h00 || tc !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset1 value=%0h tc=%b ovf=%b exp 00/0/0", value, tc, ovf);
    end
    for (int i = 1; i <= 3; i++) begin
      step_clk();
      checks++;
      if (value !== 8'(i)) begin
        failures++;
        $display("FAIL reset_count value=%0h exp=%0h", value, i);
      end
    end
    #(57 - 56) reset = 1'b1;
    #11 reset = 1'b0;
    checks++;
    if (value !== 8'h00 || tc !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset2 value=%0h tc=%b ovf=%b exp 00/0/0", value, tc, ovf);
    end
    for (int i = 0; i < 255; i++) step_clk();
    checks++;
    if (value !== 8'hFF || tc !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL count_ff value=%0h tc=%b ovf=%b exp ff/0/0", value, tc, ovf);
    end
    step_clk();
    checks++;
    if (value !== 8'h00 || tc !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL wrap_up value=%0h tc=%b ovf=%b exp 00/1/1", value, tc, ovf);
    end
    step_clk();
    checks++;
    if (value !== 8'h01 || tc !== 1'b0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL after_wrap value=%0h tc=%b ovf=%b exp 01/0/1", value, tc, ovf);
    end
  endtask

  task automatic test_modulo_down();
    logic [7:0] exp_v [7] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd5};
    logic       exp_tc[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    en = 1'b0; limit = 8'd5; up = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step_clk();
      checks++;
      if (value !== exp_v[i] || tc !== exp_tc[i]) begin
        failures++;
        $display("FAIL down_seq[%0d] value=%0d tc=%b exp %0d/%b", i, value, tc, exp_v[i], exp_tc[i]);
      end
    end
    en = 1'b0; clr_ovf = 1'b1;
    step_clk();
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0 || value !== 8'd5 || tc !== 1'b0) begin
      failures++;
      $display("FAIL clr_ovf ovf=%b value=%0d tc=%b exp 0/5/0", ovf, value, tc);
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) step_clk();
    checks++;
    if (value !== 8'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL down_to_zero value=%0d ovf=%b exp 0/0", value, ovf);
    end
    clr_ovf = 1'b1;
    step_clk();
    clr_ovf = 1'b0; en = 1'b0;
    checks++;
    if (value !== 8'd5 || tc !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL wrap_beats_clr value=%0d tc=%b ovf=%b exp 5/1/1", value, tc, ovf);
    end
  endtask

  task automatic test_load_priority();
    en = 1'b0; up = 1'b1; limit = 8'h64;
    do_reset();
    en = 1'b1; load = 1'b1; load_value = 8'hC8;
    step_clk();
    load = 1'b0;
    checks++;
    if (value !== 8'hC8 || tc !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL load_up value=%0h tc=%b ovf=%b exp c8/0/0", value, tc, ovf);
    end
    step_clk();
    checks++;
    if (value !== 8'h00 || tc !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL load_wrap value=%0h tc=%b ovf=%b exp 00/1/1", value, tc, ovf);
    end
    up = 1'b0; load = 1'b1;
    step_clk();
    load = 1'b0;
    checks++;
    if (value !== 8'hC8 || tc !== 1'b0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL load_down value=%0h tc=%b ovf=%b exp c8/0/1", value, tc, ovf);
    end
    step_clk();
    checks++;
    if (value !== 8'hC7 || tc !== 1'b0) begin
      failures++;
      $display("FAIL load_dec value=%0h tc=%b exp c7/0", value, tc);
    end
    reset = 1'b1; load = 1'b1;
    step_clk();
    reset = 1'b0; load = 1'b0; en = 1'b0;
    checks++;
    if (value !== 8'h00 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_over_load value=%0h ovf=%b exp 00/0", value, ovf);
    end
  endtask

  task automatic test_prescaler();
    logic       en_pat[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_v [5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    en = 1'b0; up = 1'b1; limit = 8'hFF;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      en = en_pat[i];
      step_clk();
      checks++;
      if (value4 !== exp_v[i] || tc4 !== 1'b0) begin
        failures++;
        $display("FAIL psc_seq[%0d] value=%0d tc=%b exp %0d/0", i, value4, tc4, exp_v[i]);
      end
    end
    en = 1'b1;
    step_clk();
    step_clk();
    load = 1'b1; load_value = 8'd10;
    step_clk();
    load = 1'b0;
    for (int i = 0; i < 3; i++) step_clk();
    checks++;
    if (value4 !== 8'd10) begin
      failures++;
      $display("FAIL psc_load_hold value=%0d exp 10", value4);
    end
    step_clk();
    en = 1'b0;
    checks++;
    if (value4 !== 8'd11) begin
      failures++;
      $display("FAIL psc_load_step value=%0d exp 11", value4);
    end
  endtask

  task automatic test_limit_zero();
    en = 1'b0; up = 1'b1; limit = 8'd0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      checks++;
      if (value !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
        failures++;
        $display("FAIL limit0[%0d] value=%0d tc=%b ovf=%b exp 0/1/1", i, value, tc, ovf);
      end
    end
    en = 1'b0;
    step_clk();
    checks++;
    if (tc !== 1'b0 || value !== 8'd0) begin
      failures++;
      $display("FAIL limit0_idle value=%0d tc=%b exp 0/0", value, tc);
    end
  endtask

  task automatic test_range_end();
`ifdef COUNTER_SATURATE_EN
    logic [7:0] exp_v [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
    logic       exp_tc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] exp_dn = 8'd0;
`else
    logic [7:0] exp_v [6] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2};
    logic       exp_tc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_dn = 8'd3;
`endif
    en = 1'b0; up = 1'b1; limit = 8'd3;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_clk();
      checks++;
      if (value !== exp_v[i] || tc !== exp_tc[i]) begin
        failures++;
        $display("FAIL range_up[%0d] value=%0d tc=%b exp %0d/%b", i, value, tc, exp_v[i], exp_tc[i]);
      end
    end
    en = 1'b0; up = 1'b0;
    do_reset();
    en = 1'b1;
    step_clk();
    en = 1'b0;
    checks++;
    if (value !== exp_dn || tc !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL range_down value=%0d tc=%b ovf=%b exp %0d/1/1", value, tc, ovf, exp_dn);
    end
  endtask

  initial begin
    test_reset();
    test_modulo_down();
    test_load_priority();
    test_prescaler();
    test_limit_zero();
    test_range_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
